unified_mem_responder: RTL and testbench
========================================

Name: unified_mem_responder

Overview:
- Memory-side responder for the pipelined ARM32 core.
- Services the fetch-stage instruction read and the memory-stage LDR/STR access from one single-port word RAM.
- Fixed 1-cycle read latency matches the core's fetch_wait and memory_wait stages.
- Arbitrates between the two requesters and returns instr/rdata with valid pulses.

Parameters:
- ADDR_W, 8, word-address width; RAM depth = 2**ADDR_W words of 32 bits.
- STARVE_MAX, 2, max consecutive data grants while fetch is pending before fetch is forced through.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  instruction read request.
- fetch_addr  in  32  byte address (PC); word index = fetch_addr[ADDR_W+1:2].
- fetch_grant  out  1  fetch accepted this cycle (combinational).
- instr_out  out  32  fetched instruction, registered.
- instr_valid  out  1  1-cycle pulse; instr_out updated.
- data_req  in  1  data access request.
- data_w_en  in  1  1 = store, 0 = load; qualified by data_req.
- data_addr  in  32  byte address; word index = data_addr[ADDR_W+1:2].
- data_wdata  in  32  store data.
- data_grant  out  1  data access accepted this cycle (combinational).
- data_rdata  out  32  load data, registered.
- data_valid  out  1  1-cycle pulse; load data ready or store complete.
- misalign_err  out  1  present only with MEM_ALIGN_CHECK_EN.

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst_n is asynchronous and active-low.
- Reset values:
  - instr_out = 0, instr_valid = 0.
  - data_rdata = 0, data_valid = 0.
  - starve_cnt = 0, state = IDLE.
  - RAM contents are not reset.
- Acceptance:
  - At most one request is granted per cycle.
  - The grant is a combinational function of the requests and the registered state.
  - A request is accepted at the rising edge where its grant = 1.
- Arbitration, with both requests high:
  - Data wins while starve_cnt < STARVE_MAX; starve_cnt increments.
  - When starve_cnt == STARVE_MAX, fetch wins; starve_cnt clears.
  - starve_cnt also clears in any cycle where fetch_req = 0 or fetch is granted.
  - A single request is always granted.
- Latency:
  - Granted read at edge N: instr_out/data_rdata load RAM[index] and instr_valid/data_valid = 1 during cycle N+1.
  - Valid pulses last exactly one cycle unless a new grant follows back-to-back.
  - Outputs hold their last value when not valid.
- Stores:
  - RAM[index] <= data_wdata at the grant edge.
  - data_valid pulses at N+1; data_rdata is unchanged.
  - A read of the same word granted at N+1 returns the new value.
- FSM, tracking the outstanding response:
  - IDLE: no grant this edge; return to IDLE.
  - RESP_F: fetch granted.
  - RESP_D: data granted.
  - From any state, the next state is decided by that cycle's grant only, so throughput is one access per cycle.
  - instr_valid = (state == RESP_F); data_valid = (state == RESP_D).
- Address rules:
  - Bits [1:0] are ignored.
  - Bits above ADDR_W+1 are ignored, so addresses wrap modulo RAM size.
- Deasserted requests: a request dropped before its grant is simply not served; no queuing.
- Reset mid-operation: a pending response is discarded and valids go 0 immediately. A store already committed at a prior edge stays in the RAM.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - misalign_err port exists.
  - A granted access with addr[1:0] != 0 sets misalign_err = 1 for the response cycle (N+1); reset value 0.
  - A misaligned store is suppressed (RAM unchanged) but still returns data_valid.
  - A misaligned load still returns the aligned word.
- Undefined:
  - No port.
  - addr[1:0] is silently ignored and all stores commit.

Test Plan:
- Reset, then fetch_req=1, fetch_addr=0x0, RAM[0]=0xE3A01005 -> fetch_grant=1; next cycle instr_valid=1, instr_out=0xE3A01005; idle cycle after -> instr_valid=0 and instr_out held.
- Store data_addr=0x10, data_wdata=0xDEADBEEF, then load 0x10 on the next cycle -> data_valid pulses on both response cycles; second data_rdata=0xDEADBEEF.
- fetch_req and data_req both held high for 6 cycles, STARVE_MAX=2 -> grant sequence D,D,F,D,D,F; instr_valid and data_valid are never both 1.
- With ADDR_W=8, load from data_addr=0x400 after a store to 0x000 of 0x12345678 -> data_rdata=0x12345678 (wrap).
- Grant a load, assert rst_n=0 before the response edge -> data_valid=0, data_rdata=0 immediately; after release the first access behaves normally.
- MEM_ALIGN_CHECK_EN: store 0xAAAAAAAA to 0x22 over RAM[8]=0x11111111, then load 0x20 -> misalign_err=1 for the store response, data_rdata=0x11111111, misalign_err=0 for the load.

Source files
------------

// File: rtl/unified_mem_responder_if.sv
// Bus between the ARM32 core (master) and the unified memory responder (slave).
// Define MEM_ALIGN_CHECK_EN to add the misalign_err response flag.
interface unified_mem_responder_if;
    // Handshake: a request is taken at the rising edge where its grant is 1. A request
    // dropped before then is lost. instr_valid/data_valid pulse for one cycle, one cycle
    // after the grant edge. The core must always accept them; there is no ready back.
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_grant;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        data_req;
    logic        data_w_en;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_grant;
    logic [31:0] data_rdata;
    logic        data_valid;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign_err;

    modport master (
        output fetch_req, fetch_addr, data_req, data_w_en, data_addr, data_wdata,
        input  fetch_grant, instr_out, instr_valid, data_grant, data_rdata, data_valid,
               misalign_err
    );
    modport slave (
        input  fetch_req, fetch_addr, data_req, data_w_en, data_addr, data_wdata,
        output fetch_grant, instr_out, instr_valid, data_grant, data_rdata, data_valid,
               misalign_err
    );
`else
    modport master (
        output fetch_req, fetch_addr, data_req, data_w_en, data_addr, data_wdata,
        input  fetch_grant, instr_out, instr_valid, data_grant, data_rdata, data_valid
    );
    modport slave (
        input  fetch_req, fetch_addr, data_req, data_w_en, data_addr, data_wdata,
        output fetch_grant, instr_out, instr_valid, data_grant, data_rdata, data_valid
    );
`endif
endinterface

// File: rtl/unified_mem_responder.sv
// Single-port word RAM that serves both fetch and data requests with a 1-cycle read latency.
// Define MEM_ALIGN_CHECK_EN to flag misaligned accesses and to block misaligned stores.
module unified_mem_responder #(
    parameter int ADDR_W     = 8,
    parameter int STARVE_MAX = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    unified_mem_responder_if.slave bus,
    output logic [1:0]            dbg_state
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RESP_F = 2'd1;
    localparam logic [1:0] RESP_D = 2'd2;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [31:0]       mem [DEPTH];
    logic [1:0]        state;
    logic [1:0]        next_state;
    logic [CNT_W-1:0]  starve_cnt;
    logic [ADDR_W-1:0] f_idx;
    logic [ADDR_W-1:0] d_idx;
    logic              grant_f;
    logic              grant_d;
    logic              store_en;

    assign f_idx = bus.fetch_addr[ADDR_W+1:2];
    assign d_idx = bus.data_addr[ADDR_W+1:2];

    // Data wins the contest until fetch has waited STARVE_MAX times in a row.
    always_comb begin
        grant_d = bus.data_req && (!bus.fetch_req || (starve_cnt < CNT_W'(STARVE_MAX)));
        grant_f = bus.fetch_req && !grant_d;
        next_state = IDLE;
        if (grant_f)      next_state = RESP_F;
        else if (grant_d) next_state = RESP_D;
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign store_en = grant_d && bus.data_w_en && (bus.data_addr[1:0] == 2'b00);
`else
    assign store_en = grant_d && bus.data_w_en;
`endif

    assign bus.fetch_grant = grant_f;
    assign bus.data_grant  = grant_d;
    assign bus.instr_valid = (state == RESP_F);
    assign bus.data_valid  = (state == RESP_D);
    assign dbg_state       = state;

    // The RAM is not reset, so writes committed before a reset survive it.
    always_ff @(posedge clk) begin
        if (store_en) mem[d_idx] <= bus.data_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            starve_cnt     <= '0;
            bus.instr_out  <= '0;
            bus.data_rdata <= '0;
        end else begin
            state <= next_state;
            if (grant_d && bus.fetch_req) starve_cnt <= starve_cnt + CNT_W'(1);
            else                          starve_cnt <= '0;
            if (grant_f) bus.instr_out <= mem[f_idx];
            if (grant_d && !bus.data_w_en) bus.data_rdata <= mem[d_idx];
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       bus.misalign_err <= 1'b0;
        else if (grant_f) bus.misalign_err <= |bus.fetch_addr[1:0];
        else if (grant_d) bus.misalign_err <= |bus.data_addr[1:0];
        else              bus.misalign_err <= 1'b0;
    end

    logic unused_hi;
    assign unused_hi = ^{bus.fetch_addr[31:ADDR_W+2], bus.data_addr[31:ADDR_W+2]};
`else
    logic unused_bits;
    assign unused_bits = ^{bus.fetch_addr[31:ADDR_W+2], bus.fetch_addr[1:0],
                           bus.data_addr[31:ADDR_W+2], bus.data_addr[1:0]};
`endif
endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed bench for unified_mem_responder; the MEM_ALIGN_CHECK_EN expectations follow the macro.
module tb_unified_mem_responder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;
    int         total = 0;
    int         bad = 0;
    logic       exp_d [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    unified_mem_responder_if bus_i ();

    unified_mem_responder #(.ADDR_W(8), .STARVE_MAX(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_i),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus_i.fetch_req  = 1'b0;
        bus_i.data_req   = 1'b0;
        bus_i.data_w_en  = 1'b0;
    endtask

    task automatic data_op(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        bus_i.data_req   = 1'b1;
        bus_i.data_w_en  = we;
        bus_i.data_addr  = addr;
        bus_i.data_wdata = wd;
    endtask

    initial begin
        idle_bus();
        bus_i.fetch_addr = 32'h0;
        bus_i.data_addr  = 32'h0;
        bus_i.data_wdata = 32'h0;
        repeat (3) cyc();

        // Reset state
        check("rst_instr_valid", {31'b0, bus_i.instr_valid}, 32'h0);
        check("rst_data_valid", {31'b0, bus_i.data_valid}, 32'h0);
        check("rst_instr_out", bus_i.instr_out, 32'h0);
        check("rst_data_rdata", bus_i.data_rdata, 32'h0);
        check("rst_state", {30'b0, dbg_state}, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        check("rst_misalign", {31'b0, bus_i.misalign_err}, 32'h0);
`endif
        rst_n = 1'b1;
        cyc();

        // Preload RAM[0] through the data port, then fetch it back
        data_op(1'b1, 32'h0, 32'hE3A01005);
        #1 check("st0_grant", {31'b0, bus_i.data_grant}, 32'h1);
        cyc();
        idle_bus();
        bus_i.fetch_req  = 1'b1;
        bus_i.fetch_addr = 32'h0;
        check("st0_valid", {31'b0, bus_i.data_valid}, 32'h1);
        check("st0_rdata_held", bus_i.data_rdata, 32'h0);
        #1 check("f0_grant", {31'b0, bus_i.fetch_grant}, 32'h1);
        check("f0_no_dgrant", {31'b0, bus_i.data_grant}, 32'h0);
        cyc();
        idle_bus();
        check("f0_valid", {31'b0, bus_i.instr_valid}, 32'h1);
        check("f0_instr", bus_i.instr_out, 32'hE3A01005);
        check("f0_no_dvalid", {31'b0, bus_i.data_valid}, 32'h0);
        cyc();
        check("f0_valid_drop", {31'b0, bus_i.instr_valid}, 32'h0);
        check("f0_instr_held", bus_i.instr_out, 32'hE3A01005);

        // Store then back-to-back load of the same word
        data_op(1'b1, 32'h10, 32'hDEADBEEF);
        cyc();
        data_op(1'b0, 32'h10, 32'h0);
        check("st10_valid", {31'b0, bus_i.data_valid}, 32'h1);
        check("st10_rdata_held", bus_i.data_rdata, 32'h0);
        cyc();
        idle_bus();
        check("ld10_valid", {31'b0, bus_i.data_valid}, 32'h1);
        check("ld10_rdata", bus_i.data_rdata, 32'hDEADBEEF);
        cyc();
        check("ld10_valid_drop", {31'b0, bus_i.data_valid}, 32'h0);

        // Both requesters held for 6 cycles: D,D,F,D,D,F
        bus_i.fetch_req  = 1'b1;
        bus_i.fetch_addr = 32'h0;
        data_op(1'b0, 32'h10, 32'h0);
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("arb%0d_dgrant", i), {31'b0, bus_i.data_grant}, {31'b0, exp_d[i]});
            check($sformatf("arb%0d_fgrant", i), {31'b0, bus_i.fetch_grant}, {31'b0, !exp_d[i]});
            cyc();
            check($sformatf("arb%0d_dvalid", i), {31'b0, bus_i.data_valid}, {31'b0, exp_d[i]});
            check($sformatf("arb%0d_ivalid", i), {31'b0, bus_i.instr_valid}, {31'b0, !exp_d[i]});
            check($sformatf("arb%0d_exclusive", i),
                  {31'b0, bus_i.data_valid & bus_i.instr_valid}, 32'h0);
        end
        idle_bus();
        cyc();

        // Address wrap: 0x400 aliases word 0
        data_op(1'b1, 32'h0, 32'h12345678);
        cyc();
        data_op(1'b0, 32'h400, 32'h0);
        cyc();
        idle_bus();
        check("wrap_rdata", bus_i.data_rdata, 32'h12345678);
        cyc();

        // Reset with a load response outstanding
        data_op(1'b0, 32'h10, 32'h0);
        cyc();
        idle_bus();
        check("pre_rst_valid", {31'b0, bus_i.data_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, bus_i.data_valid}, 32'h0);
        check("mid_rst_rdata", bus_i.data_rdata, 32'h0);
        cyc();
        rst_n = 1'b1;
        cyc();
        bus_i.fetch_req  = 1'b1;
        bus_i.fetch_addr = 32'h0;
        data_op(1'b0, 32'h10, 32'h0);
        #1 check("post_rst_dgrant", {31'b0, bus_i.data_grant}, 32'h1);
        cyc();
        check("post_rst_rdata", bus_i.data_rdata, 32'hDEADBEEF);
        bus_i.data_req = 1'b0;
        #1 check("post_rst_fgrant", {31'b0, bus_i.fetch_grant}, 32'h1);
        cyc();
        idle_bus();
        check("post_rst_instr", bus_i.instr_out, 32'h12345678);
        cyc();

        // Misaligned store over RAM[8]
        data_op(1'b1, 32'h20, 32'h11111111);
        cyc();
        data_op(1'b1, 32'h22, 32'hAAAAAAAA);
        cyc();
        data_op(1'b0, 32'h20, 32'h0);
        check("mis_st_valid", {31'b0, bus_i.data_valid}, 32'h1);
`ifdef MEM_ALIGN_CHECK_EN
        check("mis_st_err", {31'b0, bus_i.misalign_err}, 32'h1);
`endif
        cyc();
        idle_bus();
        check("mis_ld_valid", {31'b0, bus_i.data_valid}, 32'h1);
`ifdef MEM_ALIGN_CHECK_EN
        check("mis_ld_rdata", bus_i.data_rdata, 32'h11111111);
        check("mis_ld_err", {31'b0, bus_i.misalign_err}, 32'h0);
`else
        check("mis_ld_rdata", bus_i.data_rdata, 32'hAAAAAAAA);
`endif
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
